layer3_window_fetch: RTL and testbench

Downstream consumer of the layer-2 result memory. It scans the 14×14 layer-2 feature map stored in that memory and assembles 3×3 convolution windows for the layer-3 datapath, one window per valid output position (12×12, stride 1). Windows go out over a valid/ready handshake. Within a row, column reuse is exploited: the first window of each output row costs 9 reads and each later window costs 3 reads.

---
 rtl/layer3_window_pkg.sv | 10 +
 rtl/layer3_window_fetch_if.sv | 18 +
 rtl/layer3_window_addr_gen.sv | 43 ++++
 rtl/layer3_window_fetch.sv | 72 +++++++
 tb/tb_layer3_window_fetch.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/layer3_window_pkg.sv
// layer3_window_pkg: shared sizes, FSM states and tap index type for the layer-3 window fetcher
package layer3_window_pkg;
  localparam int MAP_W = 14;
  localparam int K = 3;
  localparam int OUT_W = MAP_W - K + 1;
  localparam int DATA_W = 128;
  localparam int TAPS = K * K;
  typedef enum logic [2:0] {IDLE, FILL, SLIDE, HOLD, FIN} state_t;
  typedef logic [3:0] tap_t;
endpackage

// File: rtl/layer3_window_fetch_if.sv
// layer3_window_fetch_if: layer-2 memory read port plus layer-3 window handshake
interface layer3_window_fetch_if;
  import layer3_window_pkg::*;
  logic layer2_result_read_signal;
  logic [15:0] read_row_addr, read_col_addr;
  logic [DATA_W-1:0] layer2_result_output;
  logic window_valid, window_ready;
  logic [TAPS*DATA_W-1:0] window_data;
  logic [15:0] out_row, out_col;
  modport master(
    output layer2_result_read_signal, read_row_addr, read_col_addr, window_valid, window_data, out_row, out_col,
    input layer2_result_output, window_ready
  );
  modport slave(
    input layer2_result_read_signal, read_row_addr, read_col_addr, window_valid, window_data, out_row, out_col,
    output layer2_result_output, window_ready
  );
endinterface

// File: rtl/layer3_window_addr_gen.sv
// layer3_window_addr_gen: output-position and in-window read counters with read address and tap index
module layer3_window_addr_gen
  import layer3_window_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic next_row,
  input  logic next_col,
  input  logic rd,
  input  logic slide,
  output logic [15:0] out_row,
  output logic [15:0] out_col,
  output logic [15:0] row_addr,
  output logic [15:0] col_addr,
  output tap_t tap,
  output logic last
);
  logic [1:0] dr, dc;
  always_ff @(posedge clk)
    if (rst || clear) begin
      out_row <= '0;
      out_col <= '0;
      dr <= '0;
      dc <= '0;
    end else if (next_row) begin
      out_row <= out_row + 16'd1;
      out_col <= '0;
      dr <= '0;
      dc <= '0;
    end else if (next_col) begin
      out_col <= out_col + 16'd1;
      dr <= '0;
      dc <= 2'd2;
    end else if (rd && !last) begin
      dr <= (slide || dc == 2'd2) ? dr + 2'd1 : dr;
      dc <= slide ? dc : (dc == 2'd2 ? 2'd0 : dc + 2'd1);
    end
  assign row_addr = out_row + {14'd0, dr};
  assign col_addr = out_col + {14'd0, dc};
  assign tap = {2'd0, dr} * 4'd3 + {2'd0, dc};
  assign last = dr == 2'd2 && dc == 2'd2;
endmodule

// File: rtl/layer3_window_fetch.sv
// layer3_window_fetch: scans the 14x14 layer-2 map into 3x3 windows with column reuse along each row
module layer3_window_fetch
  import layer3_window_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  layer3_window_fetch_if.master bus
);
  state_t state, state_n;
  logic issued, cap_v, rd, rd_phase, last, hs, last_col, last_row, clear, next_row, next_col;
  tap_t tap, cap_idx;
  logic [DATA_W-1:0] win [TAPS];
  logic [15:0] row_addr, col_addr, out_row, out_col;
  layer3_window_addr_gen u_addr (
    .clk(clk), .rst(rst), .clear(clear), .next_row(next_row), .next_col(next_col),
    .rd(rd), .slide(state == SLIDE), .out_row(out_row), .out_col(out_col),
    .row_addr(row_addr), .col_addr(col_addr), .tap(tap), .last(last)
  );
  assign last_col = out_col == 16'(OUT_W - 1);
  assign last_row = out_row == 16'(OUT_W - 1);
  assign hs = state == HOLD && bus.window_ready;
  assign clear = state == IDLE && start;
  assign next_col = hs && !last_col;
  assign next_row = hs && last_col && !last_row;
  assign rd_phase = state == FILL || state == SLIDE;
  assign rd = rd_phase && !issued;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:        state_n = start ? FILL : IDLE;
      FILL, SLIDE: state_n = (cap_v && cap_idx == tap_t'(TAPS - 1)) ? HOLD : state;
      HOLD:        state_n = !hs ? HOLD : next_col ? SLIDE : next_row ? FILL : FIN;
      FIN:         state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      issued <= 1'b0;
      cap_v <= 1'b0;
      cap_idx <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      issued <= rd_phase && (issued || (rd && last));
      cap_v <= rd;
      cap_idx <= tap;
      busy <= state != IDLE;
    end
  // the last tap captured in either phase is always (2,2), which ends the phase
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < TAPS; i++) win[i] <= '0;
    else if (cap_v) win[cap_idx] <= bus.layer2_result_output;
    else if (next_col)
      for (int r = 0; r < K; r++) begin
        win[r*K] <= win[r*K+1];
        win[r*K+1] <= win[r*K+2];
      end
  always_comb
    for (int i = 0; i < TAPS; i++) bus.window_data[i*DATA_W +: DATA_W] = win[i];
  assign bus.layer2_result_read_signal = rd;
  assign bus.read_row_addr = row_addr;
  assign bus.read_col_addr = col_addr;
  assign bus.window_valid = state == HOLD;
  assign bus.out_row = out_row;
  assign bus.out_col = out_col;
  assign done = state == FIN;
endmodule

// File: tb/tb_layer3_window_fetch.sv
// tb_layer3_window_fetch: scoreboard bench with a pixel-pattern memory model and randomized consumer stalls
module tb_layer3_window_fetch;
  import layer3_window_pkg::*;
  logic clk = 0, rst = 1, start = 0, busy, done;
  layer3_window_fetch_if bus();
  layer3_window_fetch dut (.clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0, errors = 0, reads = 0, wins = 0, dones = 0;
  logic [31:0] exp_pos_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] e_rd, e_pos;
  logic prev_hold = 0;
  logic [TAPS*DATA_W-1:0] prev_data, snap;

  function automatic logic [DATA_W-1:0] pix(int r, int c);
    return {8{16'(r * 16 + c)}};
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  always @(posedge clk)
    if (bus.layer2_result_read_signal)
      bus.layer2_result_output <= pix(int'(bus.read_row_addr), int'(bus.read_col_addr));

  always @(negedge clk) begin
    if (bus.layer2_result_read_signal === 1'b1) begin
      reads++;
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected actual read of %0d,%0d required none", bus.read_row_addr, bus.read_col_addr);
      end else begin
        e_rd = rd_q.pop_front();
        check("rd_addr", {bus.read_row_addr, bus.read_col_addr}, e_rd);
      end
    end
    if (bus.window_valid === 1'b1) begin
      check("rd_in_hold", bus.layer2_result_read_signal, 0);
      if (prev_hold)
        for (int t = 0; t < TAPS; t++)
          check("hold_stable", bus.window_data[t*DATA_W +: DATA_W], prev_data[t*DATA_W +: DATA_W]);
      if (bus.window_ready) begin
        wins++;
        if (exp_pos_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL win_unexpected actual window at %0d,%0d required none", bus.out_row, bus.out_col);
        end else begin
          e_pos = exp_pos_q.pop_front();
          check("win_pos", {bus.out_row, bus.out_col}, e_pos);
          for (int t = 0; t < TAPS; t++)
            check("win_tap", bus.window_data[t*DATA_W +: DATA_W],
                  pix(int'(e_pos[31:16]) + t / K, int'(e_pos[15:0]) + t % K));
        end
      end
    end
    if (done === 1'b1) dones++;
    prev_hold = bus.window_valid === 1'b1 && bus.window_ready === 1'b0;
    prev_data = bus.window_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_scan();
    for (int r = 0; r < OUT_W; r++)
      for (int c = 0; c < OUT_W; c++) begin
        exp_pos_q.push_back({16'(r), 16'(c)});
        if (c == 0) begin
          for (int dr = 0; dr < K; dr++)
            for (int dc = 0; dc < K; dc++) rd_q.push_back({16'(r + dr), 16'(c + dc)});
        end else
          for (int dr = 0; dr < K; dr++) rd_q.push_back({16'(r + dr), 16'(c + K - 1)});
      end
  endtask

  task automatic pulse_start();
    start = 1;
    push_scan();
    tick();
    start = 0;
  endtask

  task automatic finish_scan(input bit random_ready, input int r0, input int w0, input int d0);
    int n = 0;
    while (!done && n < 5000) begin
      bus.window_ready = random_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    check("scan_done", done, 1);
    tick();
    check("busy_fin", busy, 1);
    tick();
    check("busy_fall", busy, 0);
    check("reads_per_scan", reads - r0, 504);
    check("wins_per_scan", wins - w0, 144);
    check("done_pulses", dones - d0, 1);
    check("win_q_empty", exp_pos_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r0, w0, d0;
    bus.window_ready = 0;
    repeat (3) tick();
    rst = 0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", bus.window_valid, 0);
    check("rst_rd", bus.layer2_result_read_signal, 0);
    check("rst_pos", {bus.out_row, bus.out_col}, 0);
    check("rst_addr", {bus.read_row_addr, bus.read_col_addr}, 0);
    for (int t = 0; t < TAPS; t++) check("rst_data", bus.window_data[t*DATA_W +: DATA_W], 0);

    // scan with the consumer always ready
    bus.window_ready = 1;
    r0 = reads; w0 = wins; d0 = dones;
    pulse_start();
    n = 0;
    while (!bus.window_valid && n < 30) begin tick(); n++; end
    check("fill_latency", n, 10);
    check("first_tap22", bus.window_data[8*DATA_W +: DATA_W], pix(2, 2));
    check("first_pos", {bus.out_row, bus.out_col}, 0);
    n = 0;
    while (!(bus.window_valid && bus.out_row == 0 && bus.out_col == 11) && n < 200) begin tick(); n++; end
    check("reach_0_11", {bus.out_row, bus.out_col}, {16'd0, 16'd11});
    tick();
    n = 0;
    while (!bus.window_valid && n < 30) begin tick(); n++; end
    check("row_latency", n, 10);
    check("row_pos", {bus.out_row, bus.out_col}, {16'd1, 16'd0});
    finish_scan(0, r0, w0, d0);

    // stall at (0,3), with a stray start during HOLD
    bus.window_ready = 1;
    r0 = reads; w0 = wins; d0 = dones;
    pulse_start();
    n = 0;
    while (!(bus.window_valid && bus.out_row == 0 && bus.out_col == 3) && n < 200) begin tick(); n++; end
    check("reach_0_3", {bus.out_row, bus.out_col}, {16'd0, 16'd3});
    bus.window_ready = 0;
    snap = bus.window_data;
    n = reads;
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      tick();
    end
    start = 0;
    for (int t = 0; t < TAPS; t++) check("stall_data", bus.window_data[t*DATA_W +: DATA_W], snap[t*DATA_W +: DATA_W]);
    check("stall_col", bus.out_col, 3);
    check("stall_reads", reads - n, 0);
    check("stall_valid", bus.window_valid, 1);
    finish_scan(1, r0, w0, d0);

    // reset during the fifth FILL read
    bus.window_ready = 1;
    pulse_start();
    repeat (4) tick();
    check("pre_rst_rd", bus.layer2_result_read_signal, 1);
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", bus.window_valid, 0);
    for (int t = 0; t < TAPS; t++) check("mid_rst_data", bus.window_data[t*DATA_W +: DATA_W], 0);
    exp_pos_q.delete();
    rd_q.delete();
    r0 = reads; w0 = wins; d0 = dones;
    pulse_start();
    finish_scan(1, r0, w0, d0);

    // start together with rst is dropped
    n = reads;
    rst = 1;
    start = 1;
    tick();
    rst = 0;
    start = 0;
    check("sr_busy", busy, 0);
    check("sr_rd", bus.layer2_result_read_signal, 0);
    repeat (3) tick();
    check("sr_busy_late", busy, 0);
    check("sr_valid", bus.window_valid, 0);
    check("sr_reads", reads - n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
